cart_sdram_bridge: RTL and testbench

- Sits between data_io / the vectrex core cartridge port and port 1 of the SDRAM controller, on the 24 MHz system clock.
- During ROM download it turns byte-wide ioctl writes into SDRAM write requests using the controller's toggle handshake.
- During play it turns cart_rd accesses into 16-bit word reads and holds the fetched word in a one-entry cache. It returns the addressed byte, and 0xFF for addresses beyond the downloaded image.

---
 rtl/cart_bridge_pkg.sv | 25 ++
 rtl/sdram_toggle_port.sv | 46 ++++
 rtl/cart_sdram_bridge.sv | 240 ++++++++++++++++++++++++
 tb/tb_cart_sdram_bridge.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_bridge_pkg.sv
// cart_bridge_pkg: shared FSM states, constants and the write holding-register type
// for cart_sdram_bridge (PF_WAIT exists only when CART_PREFETCH_EN is defined).
package cart_bridge_pkg;

    localparam logic [7:0]  CART_FILL     = 8'hFF;
    localparam logic [15:0] CART_SIZE_MAX = 16'hFFFF;
    localparam int          WH_AW         = 24;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_WAIT = 2'd1,
        RD_WAIT = 2'd2
`ifdef CART_PREFETCH_EN
        , PF_WAIT = 2'd3
`endif
    } state_e;

    typedef struct packed {
        logic [WH_AW-1:0] addr;
        logic [1:0]       ds;
        logic [15:0]      d;
        logic             full;
    } wr_hold_t;

endpackage

// File: rtl/sdram_toggle_port.sv
// sdram_toggle_port: owns the toggle req/ack handshake toward the SDRAM controller,
// holds the request fields stable until acknowledge and pulses done on completion.
module sdram_toggle_port #(
    parameter int AW = 24
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          issue_i,
    input  logic [AW-1:0] a_i,
    input  logic          we_i,
    input  logic [1:0]    ds_i,
    input  logic [15:0]   d_i,
    input  logic          ack_i,
    output logic          req_o,
    output logic [AW-1:0] a_o,
    output logic          we_o,
    output logic [1:0]    ds_o,
    output logic [15:0]   d_o,
    output logic          done_o
);

    logic pend_q;

    assign done_o = pend_q & (ack_i == req_o);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_o  <= 1'b0;
            a_o    <= '0;
            we_o   <= 1'b0;
            ds_o   <= 2'b11;
            d_o    <= '0;
            pend_q <= 1'b0;
        end else begin
            if (issue_i) begin
                req_o <= ~req_o;
                a_o   <= a_i;
                we_o  <= we_i;
                ds_o  <= ds_i;
                d_o   <= d_i;
            end
            pend_q <= issue_i | (pend_q & ~done_o);
        end
    end

endmodule

// File: rtl/cart_sdram_bridge.sv
// cart_sdram_bridge: ROM download writes and cached cartridge word reads over SDRAM port 1.
// Optional CART_PREFETCH_EN adds a prefetched next-word buffer (state PF_WAIT).
module cart_sdram_bridge
    import cart_bridge_pkg::*;
#(
    parameter int SDRAM_AW = 24,
    parameter int CART_AW  = 15
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                ioctl_download,
    input  logic                ioctl_wr,
    input  logic [24:0]         ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    input  logic                cart_rd,
    input  logic [15:0]         cart_addr,
    output logic [7:0]          cart_do,
    output logic [15:0]         cart_size,
    output logic                sdram_req,
    input  logic                sdram_ack,
    output logic [SDRAM_AW-1:0] sdram_a,
    output logic                sdram_we,
    output logic [1:0]          sdram_ds,
    output logic [15:0]         sdram_d,
    input  logic [15:0]         sdram_q,
    output logic                busy,
    output logic                wr_overrun
);

    localparam int TW = CART_AW - 1;

    state_e        state_q, state_d;
    wr_hold_t      wh_q, wh_d;
    logic          dl_q, ovr_q, ovr_d, valid_q, valid_d, abort_q, abort_d;
    logic [15:0]   size_q, size_d, data_q, data_d, wr_end, size_base, sel;
    logic [TW-1:0] tag_q, tag_d, addr_tag, rt;
    logic [7:0]    do_q;
    logic          issue, iss_we, done, wr_issue;
    logic [SDRAM_AW-1:0] iss_a;
    logic [1:0]    iss_ds;
    logic [15:0]   iss_d;
    logic          dl_rise, aborted, rd_act, rd_ok, hit, pf_hit, miss;
`ifdef CART_PREFETCH_EN
    logic          pf_valid_q, pf_valid_d, pf_try;
    logic [TW-1:0] pf_tag_q, pf_tag_d, pf_base, pf_nt;
    logic [15:0]   pf_data_q, pf_data_d;
    logic [16:0]   pf_nxt;
`endif

    sdram_toggle_port #(.AW(SDRAM_AW)) u_port (
        .clk_i  (clk_sys),
        .rst_ni (reset_n),
        .issue_i(issue),
        .a_i    (iss_a),
        .we_i   (iss_we),
        .ds_i   (iss_ds),
        .d_i    (iss_d),
        .ack_i  (sdram_ack),
        .req_o  (sdram_req),
        .a_o    (sdram_a),
        .we_o   (sdram_we),
        .ds_o   (sdram_ds),
        .d_o    (sdram_d),
        .done_o (done)
    );

    assign busy       = (state_q != IDLE) | wh_q.full;
    assign wr_overrun = ovr_q;
    assign cart_size  = size_q;

    always_comb begin
        dl_rise  = ioctl_download & ~dl_q;
        aborted  = abort_q | dl_rise;
        addr_tag = cart_addr[CART_AW-1:1];
        rt       = sdram_a[TW-1:0];
        rd_act   = cart_rd & ~ioctl_download;
        rd_ok    = rd_act & ~cart_addr[15] & (cart_addr < size_q);
        hit      = rd_ok & valid_q & (tag_q == addr_tag);
`ifdef CART_PREFETCH_EN
        pf_hit   = rd_ok & ~hit & pf_valid_q & (pf_tag_q == addr_tag) & (state_q == IDLE) & ~wh_q.full;
        sel      = pf_hit ? pf_data_q : data_q;
`else
        pf_hit   = 1'b0;
        sel      = data_q;
`endif
        miss     = rd_ok & ~hit & ~pf_hit;
        // A pending miss keeps showing the last returned byte until its data lands.
        cart_do  = !rd_act ? do_q : !rd_ok ? CART_FILL :
                   (hit | pf_hit) ? (cart_addr[0] ? sel[15:8] : sel[7:0]) : do_q;
        wr_end    = (ioctl_addr >= 25'(CART_SIZE_MAX)) ? CART_SIZE_MAX : ioctl_addr[15:0] + 16'd1;
        size_base = dl_rise ? 16'd0 : size_q;
        size_d    = (ioctl_wr && wr_end > size_base) ? wr_end : size_base;
        state_d  = state_q;
        issue    = 1'b0;
        wr_issue = 1'b0;
        iss_a    = SDRAM_AW'(addr_tag);
        iss_we   = 1'b0;
        iss_ds   = 2'b11;
        iss_d    = 16'h0;
        valid_d  = valid_q & ~dl_rise;
        tag_d    = tag_q;
        data_d   = data_q;
        abort_d  = aborted;
`ifdef CART_PREFETCH_EN
        pf_valid_d = pf_valid_q & ~dl_rise;
        pf_tag_d   = pf_tag_q;
        pf_data_d  = pf_data_q;
        pf_try     = 1'b0;
        pf_base    = tag_q;
`endif
        case (state_q)
            IDLE: begin
                if (wh_q.full) begin
                    wr_issue = 1'b1;
                end else if (miss) begin
                    issue   = 1'b1;
                    abort_d = 1'b0;
                    state_d = RD_WAIT;
                end
`ifdef CART_PREFETCH_EN
                else if (pf_hit) begin
                    valid_d    = 1'b1;
                    tag_d      = pf_tag_q;
                    data_d     = pf_data_q;
                    pf_valid_d = 1'b0;
                    pf_base    = pf_tag_q;
                    pf_try     = 1'b1;
                end
`endif
            end
            WR_WAIT: begin
                if (done) begin
                    if (wh_q.full) wr_issue = 1'b1;
                    else state_d = IDLE;
                end
            end
            RD_WAIT: begin
                if (done) begin
                    state_d = IDLE;
                    if (!aborted) begin
                        valid_d = 1'b1;
                        tag_d   = rt;
                        data_d  = sdram_q;
`ifdef CART_PREFETCH_EN
                        pf_base = rt;
                        pf_try  = 1'b1;
`endif
                    end
                end
            end
`ifdef CART_PREFETCH_EN
            PF_WAIT: begin
                if (done) begin
                    state_d = IDLE;
                    if (!aborted) begin
                        pf_valid_d = 1'b1;
                        pf_tag_d   = rt;
                        pf_data_d  = sdram_q;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        if (wr_issue) begin
            issue   = 1'b1;
            iss_a   = SDRAM_AW'(wh_q.addr);
            iss_we  = 1'b1;
            iss_ds  = wh_q.ds;
            iss_d   = wh_q.d;
            state_d = WR_WAIT;
        end
`ifdef CART_PREFETCH_EN
        pf_nt  = pf_base + 1'b1;
        pf_nxt = 17'({pf_base, 1'b0}) + 17'd2;
        // Stop at the image end and never wrap past the cartridge window.
        if (pf_try && !pf_nxt[CART_AW] && pf_nxt < {1'b0, size_q}) begin
            issue      = 1'b1;
            iss_a      = SDRAM_AW'(pf_nt);
            abort_d    = 1'b0;
            pf_valid_d = 1'b0;
            state_d    = PF_WAIT;
        end
`endif
        wh_d  = wh_q;
        ovr_d = ovr_q & ~dl_rise;
        if (wr_issue) wh_d.full = 1'b0;
        if (ioctl_wr) begin
            if (wh_q.full && !wr_issue) begin
                ovr_d = 1'b1;
            end else begin
                wh_d.addr = WH_AW'(ioctl_addr[SDRAM_AW:1]);
                wh_d.ds   = {ioctl_addr[0], ~ioctl_addr[0]};
                wh_d.d    = {ioctl_dout, ioctl_dout};
                wh_d.full = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wh_q    <= '0;
            dl_q    <= 1'b0;
            ovr_q   <= 1'b0;
            valid_q <= 1'b0;
            abort_q <= 1'b0;
            size_q  <= '0;
            tag_q   <= '0;
            data_q  <= '0;
            do_q    <= CART_FILL;
        end else begin
            state_q <= state_d;
            wh_q    <= wh_d;
            dl_q    <= ioctl_download;
            ovr_q   <= ovr_d;
            valid_q <= valid_d;
            abort_q <= abort_d;
            size_q  <= size_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            do_q    <= cart_do;
        end
    end

`ifdef CART_PREFETCH_EN
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pf_valid_q <= 1'b0;
            pf_tag_q   <= '0;
            pf_data_q  <= '0;
        end else begin
            pf_valid_q <= pf_valid_d;
            pf_tag_q   <= pf_tag_d;
            pf_data_q  <= pf_data_d;
        end
    end
`endif

endmodule

// File: tb/tb_cart_sdram_bridge.sv
// tb_cart_sdram_bridge: directed self-checking bench with a toggle-handshake SDRAM model
// whose acknowledge latency is adjustable per test.
module tb_cart_sdram_bridge;

`ifdef CART_PREFETCH_EN
    localparam int PF = 1;
`else
    localparam int PF = 0;
`endif

    logic        clk_sys = 1'b0, reset_n = 1'b0;
    logic        ioctl_download = 1'b0, ioctl_wr = 1'b0, cart_rd = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [15:0] cart_addr = '0;
    logic [7:0]  cart_do;
    logic [15:0] cart_size, sdram_d, sdram_q;
    logic        sdram_req, sdram_ack, sdram_we, busy, wr_overrun;
    logic [23:0] sdram_a;
    logic [1:0]  sdram_ds;

    int n_chk = 0, n_fail = 0;

    logic [15:0] mem [16];
    logic [23:0] log_a [64];
    logic [1:0]  log_ds [64];
    logic [15:0] log_d [64];
    logic        log_we [64];
    int          nreq = 0, cnt = 0, ack_dly = 2;

    always #20 clk_sys = ~clk_sys;

    cart_sdram_bridge dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .cart_rd       (cart_rd),
        .cart_addr     (cart_addr),
        .cart_do       (cart_do),
        .cart_size     (cart_size),
        .sdram_req     (sdram_req),
        .sdram_ack     (sdram_ack),
        .sdram_a       (sdram_a),
        .sdram_we      (sdram_we),
        .sdram_ds      (sdram_ds),
        .sdram_d       (sdram_d),
        .sdram_q       (sdram_q),
        .busy          (busy),
        .wr_overrun    (wr_overrun)
    );

    // SDRAM controller model: acknowledges ack_dly+1 cycles after a request toggle.
    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sdram_ack <= 1'b0;
            cnt       <= 0;
        end else if (sdram_req != sdram_ack) begin
            if (cnt < ack_dly) begin
                cnt <= cnt + 1;
            end else begin
                cnt       <= 0;
                sdram_ack <= sdram_req;
                log_a[nreq[5:0]]  <= sdram_a;
                log_ds[nreq[5:0]] <= sdram_ds;
                log_d[nreq[5:0]]  <= sdram_d;
                log_we[nreq[5:0]] <= sdram_we;
                nreq <= nreq + 1;
                if (sdram_we) begin
                    if (sdram_ds[0]) mem[sdram_a[3:0]][7:0]  <= sdram_d[7:0];
                    if (sdram_ds[1]) mem[sdram_a[3:0]][15:8] <= sdram_d[15:8];
                end else begin
                    sdram_q <= mem[sdram_a[3:0]];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic dl_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick(1);
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_ack(input int base);
        for (int i = 0; i < 100 && nreq <= base; i++) tick(1);
        if (nreq <= base) check("ack timeout", nreq, base + 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) tick(1);
        if (busy) check("idle timeout", busy, 0);
    endtask

    task automatic download4();
        logic [7:0] b [4];
        b = '{8'h11, 8'h22, 8'h33, 8'h44};
        ack_dly = 2;
        ioctl_download = 1'b1;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            dl_byte(25'(i), b[i]);
            tick(7);
        end
        wait_idle();
        ioctl_download = 1'b0;
        tick(1);
    endtask

    initial begin
        int base;
        logic r;
        tick(3);
        reset_n = 1'b1;
        tick(1);
        check("rst req", sdram_req, 0);
        check("rst we", sdram_we, 0);
        check("rst ds", sdram_ds, 2'b11);
        check("rst a", sdram_a, 0);
        check("rst d", sdram_d, 0);
        check("rst size", cart_size, 0);
        check("rst busy", busy, 0);
        check("rst ovr", wr_overrun, 0);
        check("rst do", cart_do, 8'hFF);

        download4();
        check("dl nreq", nreq, 4);
        check("dl0 a", log_a[0], 0);
        check("dl0 ds", log_ds[0], 2'b01);
        check("dl0 d", log_d[0], 16'h1111);
        check("dl1 ds", log_ds[1], 2'b10);
        check("dl1 d", log_d[1], 16'h2222);
        check("dl2 a", log_a[2], 1);
        check("dl2 d", log_d[2], 16'h3333);
        check("dl3 ds", log_ds[3], 2'b10);
        check("dl3 we", log_we[3], 1);
        check("dl size", cart_size, 4);
        check("dl ovr", wr_overrun, 0);

        base = nreq;
        cart_rd = 1'b1;
        cart_addr = 16'h0001;
        wait_ack(base);
        check("rd hold", cart_do, 8'hFF);
        tick(1);
        check("rd 0001", cart_do, 8'h22);
        check("rd we", log_we[base], 0);
        check("rd a", log_a[base], 0);
        check("rd ds", log_ds[base], 2'b11);
        wait_idle();
        cart_addr = 16'h0000;
        tick(1);
        check("rd 0000", cart_do, 8'h11);
        check("rd hit nreq", nreq, base + 1 + PF);

        base = nreq;
        r = sdram_req;
        cart_addr = 16'h0010;
        tick(3);
        check("oob 0010", cart_do, 8'hFF);
        check("oob req", sdram_req, r);
        check("oob busy", busy, 0);
        cart_addr = 16'h0004;
        tick(1);
        check("oob size", cart_do, 8'hFF);
        cart_addr = 16'h8000;
        tick(1);
        check("oob 8000", cart_do, 8'hFF);
        check("oob nreq", nreq, base);
        cart_rd = 1'b0;
        tick(1);

        download4();
        ack_dly = 10;
        cart_rd = 1'b1;
        cart_addr = 16'h0002;
        tick(2);
        check("rw busy", busy, 1);
        reset_n = 1'b0;
        tick(1);
        check("rst mid busy", busy, 0);
        check("rst mid do", cart_do, 8'hFF);
        check("rst mid req", sdram_req, 0);
        reset_n = 1'b1;
        cart_rd = 1'b0;
        ack_dly = 2;
        tick(1);
        ioctl_download = 1'b1;
        tick(1);
        dl_byte(25'h3, 8'h44);
        wait_idle();
        ioctl_download = 1'b0;
        tick(1);
        check("redl size", cart_size, 4);
        base = nreq;
        cart_rd = 1'b1;
        cart_addr = 16'h0002;
        wait_ack(base);
        tick(1);
        check("refetch do", cart_do, 8'h33);
        check("refetch a", log_a[base], 1);
        check("refetch we", log_we[base], 0);
        check("refetch nreq", nreq, base + 1);
        cart_rd = 1'b0;
        wait_idle();

        ack_dly = 10;
        ioctl_download = 1'b1;
        tick(1);
        base = nreq;
        dl_byte(25'h0, 8'hA1);
        dl_byte(25'h1, 8'hB2);
        dl_byte(25'h2, 8'hC3);
        check("ovr flag", wr_overrun, 1);
        check("ovr busy", busy, 1);
        wait_idle();
        check("ovr nreq", nreq, base + 2);
        check("ovr w0 d", log_d[base], 16'hA1A1);
        check("ovr w0 ds", log_ds[base], 2'b01);
        check("ovr w1 d", log_d[base + 1], 16'hB2B2);
        check("ovr w1 ds", log_ds[base + 1], 2'b10);
        check("ovr mem", mem[0], 16'hB2A1);
        ioctl_download = 1'b0;
        tick(1);
        ioctl_download = 1'b1;
        tick(1);
        check("rise ovr clr", wr_overrun, 0);
        check("rise size clr", cart_size, 0);

        ack_dly = 2;
        dl_byte(25'h00FFFE, 8'h5A);
        wait_idle();
        check("sat fffe", cart_size, 16'hFFFF);
        check("sat a", log_a[nreq - 1], 24'h7FFF);
        dl_byte(25'h5, 8'h5B);
        wait_idle();
        check("sat keep", cart_size, 16'hFFFF);
        ioctl_download = 1'b0;
        tick(1);
        ioctl_download = 1'b1;
        tick(1);
        dl_byte(25'h1000005, 8'h5C);
        wait_idle();
        check("sat big", cart_size, 16'hFFFF);
        check("sat big a", log_a[nreq - 1], 24'h800002);
        ioctl_download = 1'b0;
        tick(1);

`ifdef CART_PREFETCH_EN
        download4();
        base = nreq;
        cart_rd = 1'b1;
        cart_addr = 16'h0000;
        wait_ack(base);
        tick(1);
        check("pf rd0", cart_do, 8'h11);
        wait_idle();
        check("pf nreq", nreq, base + 2);
        check("pf a", log_a[base + 1], 1);
        check("pf we", log_we[base + 1], 0);
        cart_addr = 16'h0002;
        tick(1);
        check("pf hit", cart_do, 8'h33);
        tick(3);
        check("pf no req", nreq, base + 2);
        cart_rd = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
